// File: rtl/cellram_responder_if.sv
// Control, address and status pins between a CellularRAM controller and cellram_responder.
// The dq data bus is a plain inout port on the responder, outside this interface.
interface cellram_responder_if;
    logic        iCE_n;
    logic        iOE_n;
    logic        iWE_n;
    logic        iADV_n;
    logic        iCRE;
    logic        iLB_n;
    logic        iUB_n;
    logic [22:0] iAddr;
    logic        oWait;
    logic        oReady;

    modport master (output iCE_n, iOE_n, iWE_n, iADV_n, iCRE, iLB_n, iUB_n, iAddr,
                    input  oWait, oReady);
    modport slave  (input  iCE_n, iOE_n, iWE_n, iADV_n, iCRE, iLB_n, iUB_n, iAddr,
                    output oWait, oReady);
endinterface

// File: rtl/cellram_responder.sv
// Device-side model of an asynchronous CellularRAM: word reads, byte-lane writes, BCR/RCR/DIDR.
// Define CELLRAM_CREG_EN to build the configuration registers; without it CRE accesses are ignored.
module cellram_responder #(
    parameter int          PU_CYCLES  = 7500,
    parameter int          READ_LAT   = 5,
    parameter int          MEM_AW     = 10,
    parameter logic [15:0] DIDR_VALUE = 16'h0343
) (
    input  logic               iClock,
    input  logic               iReset,
    cellram_responder_if.slave bus,
    inout  wire  [15:0]        dq
);
    localparam int PUW  = $clog2(PU_CYCLES + 1);
    localparam int LATW = $clog2(READ_LAT + 1);
    localparam logic [LATW-1:0] LAT_INIT = LATW'(READ_LAT - 1);

    typedef enum logic [1:0] {POWERUP, IDLE, READ, WRITE} state_t;

    state_t          state;
    logic [PUW-1:0]  puCnt;
    logic [LATW-1:0] latCnt;

    // Registered pin samples; the FSM only ever looks at these.
    logic        ceS, oeS, weS, advS, creS, lbS, ubS;
    logic [22:0] addrS;
    logic [15:0] dqS;

    logic [22:0] addrQ;
    logic [15:0] wdataQ;
    logic [1:0]  beQ;
    logic [15:0] rdata;
    logic        dqOe;
    logic [15:0] readWord;
    logic        memWe;
    logic        creBlk;
    logic        addrChg;

    logic [15:0] mem [2**MEM_AW];

`ifdef CELLRAM_CREG_EN
    logic        creQ;
    logic [15:0] bcr, rcr;
    assign creBlk = 1'b0;
`else
    // Without configuration registers a CRE access never leaves IDLE.
    assign creBlk = creS;
`endif

    assign addrChg = !ceS && !advS && (addrS != addrQ);

    always_comb begin
        readWord = mem[addrQ[MEM_AW-1:0]];
`ifdef CELLRAM_CREG_EN
        if (creQ) begin
            case (addrQ[19:18])
                2'b00:   readWord = rcr;
                2'b10:   readWord = bcr;
                2'b01:   readWord = DIDR_VALUE;
                default: readWord = 16'h0000;
            endcase
        end
`endif
    end

    // Commit happens on the first sampled strobe-high cycle; reset in that cycle discards it.
    assign memWe = (state == WRITE) && (weS || ceS) && !iReset
`ifdef CELLRAM_CREG_EN
                   && !creQ
`endif
                   ;

    always_ff @(posedge iClock) begin
        if (memWe) begin
            if (!beQ[0]) mem[addrQ[MEM_AW-1:0]][7:0]  <= wdataQ[7:0];
            if (!beQ[1]) mem[addrQ[MEM_AW-1:0]][15:8] <= wdataQ[15:8];
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            ceS        <= 1'b1;
            oeS        <= 1'b1;
            weS        <= 1'b1;
            advS       <= 1'b1;
            creS       <= 1'b0;
            lbS        <= 1'b1;
            ubS        <= 1'b1;
            addrS      <= '0;
            dqS        <= '0;
            state      <= POWERUP;
            puCnt      <= '0;
            latCnt     <= '0;
            addrQ      <= '0;
            wdataQ     <= '0;
            beQ        <= 2'b11;
            rdata      <= '0;
            dqOe       <= 1'b0;
            bus.oWait  <= 1'b0;
            bus.oReady <= 1'b0;
`ifdef CELLRAM_CREG_EN
            creQ       <= 1'b0;
            bcr        <= 16'h9D1F;
            rcr        <= 16'h0010;
`endif
        end else begin
            ceS   <= bus.iCE_n;
            oeS   <= bus.iOE_n;
            weS   <= bus.iWE_n;
            advS  <= bus.iADV_n;
            creS  <= bus.iCRE;
            lbS   <= bus.iLB_n;
            ubS   <= bus.iUB_n;
            addrS <= bus.iAddr;
            dqS   <= dq;

            dqOe      <= 1'b0;
            bus.oWait <= 1'b0;

            if (state != POWERUP && !ceS && !advS) begin
                addrQ <= addrS;
`ifdef CELLRAM_CREG_EN
                creQ  <= creS;
`endif
            end

            case (state)
                POWERUP: begin
                    if (puCnt == PUW'(PU_CYCLES - 1)) begin
                        state      <= IDLE;
                        bus.oReady <= 1'b1;
                    end else begin
                        puCnt <= puCnt + 1'b1;
                    end
                end

                IDLE: begin
                    if (!ceS && !creBlk) begin
                        if (!weS) begin
                            state  <= WRITE;
                            wdataQ <= dqS;
                            beQ    <= {ubS, lbS};
                        end else if (!oeS) begin
                            state  <= READ;
                            latCnt <= LAT_INIT;
                        end
                    end
                end

                READ: begin
                    if (ceS) begin
                        state <= IDLE;
                    end else if (!weS && !creBlk) begin
                        state  <= WRITE;
                        wdataQ <= dqS;
                        beQ    <= {ubS, lbS};
                    end else if (oeS || !weS) begin
                        state <= IDLE;
                    end else if (addrChg) begin
                        // New address mid-read restarts the access latency.
                        latCnt    <= LAT_INIT;
                        bus.oWait <= 1'b1;
                    end else if (latCnt != '0) begin
                        latCnt    <= latCnt - 1'b1;
                        bus.oWait <= 1'b1;
                    end else begin
                        dqOe  <= 1'b1;
                        rdata <= readWord;
                    end
                end

                WRITE: begin
                    if (!weS && !ceS) begin
                        wdataQ <= dqS;
                        beQ    <= {ubS, lbS};
                    end else begin
`ifdef CELLRAM_CREG_EN
                        if (creQ) begin
                            case (addrQ[19:18])
                                2'b00:   rcr <= addrQ[15:0];
                                2'b10:   bcr <= addrQ[15:0];
                                default: ;
                            endcase
                        end
`endif
                        if (!ceS && !oeS && weS && !creBlk) begin
                            state  <= READ;
                            latCnt <= LAT_INIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= POWERUP;
            endcase
        end
    end

    assign dq = dqOe ? rdata : 16'hzzzz;
endmodule

// File: tb/tb_cellram_responder.sv
// Directed bench for cellram_responder; a released dq bus reads back as 16'hFFFF via pull-ups.
module tb_cellram_responder;
    localparam int          PU = 7500;
    localparam logic [15:0] ZV = 16'hFFFF;

    logic        iClock;
    logic        iReset;
    logic        tbDrv;
    logic [15:0] tbData;
    wire  [15:0] dq;
    int          checks;
    int          errors;
    logic        bad;

    cellram_responder_if bus();

    cellram_responder #(
        .PU_CYCLES (PU),
        .READ_LAT  (5),
        .MEM_AW    (10),
        .DIDR_VALUE(16'h0343)
    ) dut (
        .iClock(iClock),
        .iReset(iReset),
        .bus   (bus),
        .dq    (dq)
    );

    assign dq = tbDrv ? tbData : 16'hzzzz;

    for (genvar i = 0; i < 16; i++) begin : g_pu
        pullup pu (dq[i]);
    end

    initial iClock = 1'b0;
    always #10 iClock = ~iClock;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idlePins();
        bus.iCE_n  = 1'b1;
        bus.iOE_n  = 1'b1;
        bus.iWE_n  = 1'b1;
        bus.iADV_n = 1'b1;
        bus.iCRE   = 1'b0;
        bus.iLB_n  = 1'b1;
        bus.iUB_n  = 1'b1;
        tbDrv      = 1'b0;
    endtask

    task automatic doWrite(input logic [22:0] a, input logic c, input logic [15:0] d,
                           input logic lb, input logic ub);
        bus.iCE_n = 1'b0; bus.iOE_n = 1'b1; bus.iWE_n = 1'b0; bus.iADV_n = 1'b0;
        bus.iCRE  = c;    bus.iAddr = a;    bus.iLB_n = lb;   bus.iUB_n  = ub;
        tbDrv = 1'b1; tbData = d;
        tick();
        tick();
        idlePins();
        tick();
        tick();
    endtask

    // Read starting at edge 0; oWait counted over edges 1..5, data expected after edge 6.
    task automatic doRead(input string tag, input logic [22:0] a, input logic c,
                          input int expWait, input logic [15:0] expData);
        int w;
        w = 0;
        bus.iCE_n = 1'b0; bus.iOE_n = 1'b0; bus.iWE_n = 1'b1; bus.iADV_n = 1'b0;
        bus.iCRE  = c;    bus.iAddr = a;    tbDrv = 1'b0;
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (bus.oWait === 1'b1) w++;
        end
        chk({tag, "_prez"}, dq, ZV);
        chk({tag, "_wait"}, w, expWait);
        tick();
        chk({tag, "_data"}, dq, expData);
        chk({tag, "_waitlo"}, bus.oWait, 1'b0);
        idlePins();
        tick();
        chk({tag, "_hold"}, dq, expData);
        tick();
        chk({tag, "_rel"}, dq, ZV);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.iAddr = '0;
        tbData = '0;
        idlePins();

        // Reset and power-up quiet period
        iReset = 1'b1;
        tick();
        chk("rst_ready", bus.oReady, 1'b0);
        chk("rst_wait",  bus.oWait,  1'b0);
        chk("rst_dq",    dq,         ZV);
        iReset = 1'b0;
        bad = 1'b0;
        for (int n = 1; n <= PU; n++) begin
            if (n == 100) begin bus.iCE_n = 1'b0; bus.iOE_n = 1'b0; end
            tick();
            if (n < PU && (bus.oReady !== 1'b0 || dq !== ZV)) bad = 1'b1;
            if (n == PU - 1) chk("ready_pre", bus.oReady, 1'b0);
        end
        chk("ready_post", bus.oReady, 1'b1);
        chk("pu_quiet",   bad,        1'b0);
        chk("pu_dq",      dq,         ZV);
        idlePins();
        tick(); tick(); tick();

        // Full-word write and read latency
        doWrite(23'h3, 1'b0, 16'hA5C3, 1'b0, 1'b0);
        doRead("rd3", 23'h3, 1'b0, 4, 16'hA5C3);

        // Byte-lane write: upper lane only
        doWrite(23'h7, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        doWrite(23'h7, 1'b0, 16'h1200, 1'b1, 1'b0);
        doRead("rd7", 23'h7, 1'b0, 4, 16'h12FF);

        // Upper address bits beyond the array are ignored
        doRead("alias", 23'h400003, 1'b0, 4, 16'hA5C3);

        // Address change mid-read restarts latency
        bus.iCE_n = 1'b0; bus.iOE_n = 1'b0; bus.iWE_n = 1'b1; bus.iADV_n = 1'b0;
        bus.iCRE = 1'b0; bus.iAddr = 23'h3;
        tick();
        tick();
        tick();
        bus.iAddr = 23'h7;
        for (int i = 3; i <= 8; i++) begin
            tick();
            if (i == 6) chk("reld_z6", dq, ZV);
            if (i == 8) begin
                chk("reld_z8",  dq,        ZV);
                chk("reld_w8",  bus.oWait, 1'b1);
            end
        end
        tick();
        chk("reld_data", dq, 16'h12FF);
        idlePins();
        tick(); tick(); tick();

        // Configuration register accesses; array below the CRE write must stay intact
        doWrite(23'h11F, 1'b0, 16'h5A5A, 1'b0, 1'b0);
        doWrite(23'h081D1F, 1'b1, 16'hBEEF, 1'b0, 1'b0);
`ifdef CELLRAM_CREG_EN
        doRead("bcr",  23'h080000, 1'b1, 4, 16'h1D1F);
        doRead("didr", 23'h040000, 1'b1, 4, 16'h0343);
        doRead("rcr",  23'h000000, 1'b1, 4, 16'h0010);
        doRead("c11",  23'h0C0000, 1'b1, 4, 16'h0000);
`else
        doRead("bcr",  23'h080000, 1'b1, 0, ZV);
        doRead("didr", 23'h040000, 1'b1, 0, ZV);
`endif
        doRead("mem11f", 23'h11F, 1'b0, 4, 16'h5A5A);

        // Reset in the strobe-high cycle discards the pending write
        doWrite(23'h5, 1'b0, 16'h1111, 1'b0, 1'b0);
        bus.iCE_n = 1'b0; bus.iOE_n = 1'b1; bus.iWE_n = 1'b0; bus.iADV_n = 1'b0;
        bus.iAddr = 23'h5; bus.iLB_n = 1'b0; bus.iUB_n = 1'b0;
        tbDrv = 1'b1; tbData = 16'h2222;
        tick();
        tick();
        idlePins();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        chk("mrst_ready", bus.oReady, 1'b0);
        chk("mrst_dq",    dq,         ZV);
        for (int n = 1; n <= PU; n++) tick();
        chk("mrst_ready2", bus.oReady, 1'b1);
        tick();
        doRead("rd5", 23'h5, 1'b0, 4, 16'h1111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cellram_responder.md
# cellram_responder

Synthesizable responder for the asynchronous CellularRAM pin interface; it is the device end of the interface our RAM controller drives. It sits at the memory boundary in FPGA-only builds and in the verification harness. It samples CE#/OE#/WE#/ADV#/CRE/LB#/UB#/address on every clock and serves word reads and byte-lane writes from an internal array. It also serves Bus/Refresh Configuration Register accesses and the Device ID Register.

## Interface
- PU_CYCLES, 7500: power-up cycles during which all pins are ignored (150 us at 20 ns).
- READ_LAT, 5: cycles from access start to valid read data (ceil(85 ns / 20 ns)).
- MEM_AW, 10: internal array depth 2^MEM_AW words; iAddr[MEM_AW-1:0] used, upper bits ignored.
- DIDR_VALUE, 16'h0343: read-only Device ID Register value.
- iClock  in  1  sole clock; every pin is sampled on its rising edge.
- iReset  in  1  reset; synchronous and active-high.
- iCE_n  in  1  chip enable, low-active.
- iOE_n  in  1  output enable, low-active.
- iWE_n  in  1  write enable, low-active.
- iADV_n  in  1  address valid, low-active; the address latch is transparent while low.
- iCRE  in  1  control-register access select.
- iLB_n / iUB_n  in  1 each  lower/upper byte enables, low-active.
- iAddr  in  23  address.
- dq  inout  16  data bus.
- oWait  out  1  high while a read's latency count is pending.
- oReady  out  1  high once power-up has finished.

## Operation
- **States:** POWERUP, IDLE, READ, WRITE.
- **Reset (synchronous):**
  - state=POWERUP, lat_cnt=0, pu_cnt=0.
  - BCR=16'h9D1F, RCR=16'h0010.
  - oWait=0, oReady=0, dq=Z.
  - Array contents are not reset.
- **POWERUP:**
  - pu_cnt increments every cycle.
  - When pu_cnt==PU_CYCLES-1, go to IDLE and set oReady=1.
  - All pins are ignored; dq=Z.
- **Address latch:** while iCE_n=0 and iADV_n=0, addr_q<=iAddr and cre_q<=iCRE each cycle; the values hold while iADV_n=1.
- **IDLE:**
  - iCE_n=0 & iWE_n=0 → WRITE.
  - iCE_n=0 & iWE_n=1 & iOE_n=0 → READ, with lat_cnt loaded to READ_LAT-1.
- **READ:**
  - lat_cnt decrements to 0; oWait=1 while lat_cnt≠0.
  - Once lat_cnt==0, drive dq with the word at addr_q.
  - With cre_q=1, the word comes from the register selected by addr_q[19:18]: 00 RCR, 10 BCR, 01 DIDR, 11 returns 16'h0000.
  - A change of the latched address during READ reloads lat_cnt to READ_LAT-1 (dq=Z until expiry).
  - iCE_n=1 or iOE_n=1 → IDLE, dq=Z next cycle.
  - iWE_n=0 → WRITE.
- **WRITE:**
  - Every cycle with iWE_n=0: capture dq into wdata_q and iLB_n/iUB_n into be_q.
  - Commit occurs on the first sampled cycle with iWE_n=1 or iCE_n=1 (write-strobe rising edge), using the captured values. The array is updated only on lanes whose enable was low.
  - Then → IDLE, or → READ when iCE_n=0 & iOE_n=0 & iWE_n=1.
  - With cre_q=1, commit writes addr_q[15:0] (not dq) to the register selected by addr_q[19:18]. DIDR and code 11 are no-ops.
- **dq drive condition:** state==READ & lat_cnt==0 & iCE_n=0 & iOE_n=0 & iWE_n=1; otherwise Z. The responder never drives during WRITE.
- **Simultaneous iWE_n=0 and iOE_n=0:** write wins.

## Timing
- Inputs are registered once before use.
- Read data is valid READ_LAT+1 cycles after the first cycle in which CE#=0, OE#=0 and WE#=1 are sampled together.
- dq returns to Z one cycle after OE# or CE# is sampled high.
- A write commits one cycle after the strobe rising edge is sampled; a read in the cycle after commit returns the new data.
- Back-to-back accesses require no idle cycle; CE# may stay low across them.
- Reset asserted mid-access:
  - A pending write is discarded.
  - The responder re-enters POWERUP.
  - dq=Z on the cycle after reset is sampled.

## Configuration
- **CELLRAM_CREG_EN defined:** CRE accesses are served as above; BCR and RCR exist.
- **CELLRAM_CREG_EN undefined:**
  - The BCR/RCR/DIDR logic is removed and cre_q is forced to 0.
  - CRE=1 reads leave dq=Z and oWait=0.
  - CRE=1 writes are dropped without touching the array.

## Test plan
- Assert iReset, then drive CE#=0/OE#=0 at cycle 100 → dq stays Z, oReady=0 until cycle PU_CYCLES; oReady=1 afterwards.
- Write 16'hA5C3 to addr 0x3 (LB#=UB#=0), then read 0x3 → oWait high for 4 cycles, dq=16'hA5C3 on cycle 6.
- Write 16'hFFFF to addr 0x7, then write 16'h1200 with LB#=1 → readback 16'h12FF.
- During a read of 0x3, change iAddr to 0x7 with ADV#=0 at cycle 3 → lat_cnt reloads, dq=Z, then data of 0x7 five cycles later.
- With CRE=1, addr[19:18]=10: write with addr[15:0]=16'h1D1F, then read BCR → dq=16'h1D1F; a read with addr[19:18]=01 returns 16'h0343; repeating with the macro undefined leaves dq Z.
- Assert iReset in the cycle WE# is sampled high after a write to addr 0x5 → after power-up, addr 0x5 still holds its old value.
